// File: rtl/store_merge_buffer.sv
// -----------------------------------------------------------------------------
// store_merge_buffer
//   Store queue between the CPU memory stage and the data cache/RAM. SB/SH/SW
//   stores are queued as {word address, lane-replicated data, byte mask} and
//   drained strictly in order. Partial-word entries go through a
//   read-modify-write sequence (IDLE -> READ -> WRITE). Full-word entries go
//   straight to WRITE (IDLE -> WRITE).
//
//   Optional feature: define STORE_COALESCE_EN to merge a store into the tail
//   entry when both target the same word. Merging is allowed even when the
//   queue is full, provided the FSM does not currently own the tail.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   st_valid/st_ready    store handshake (st_ready = !full)
//   st_size              00 byte, 01 half, 10 word, 11 reserved (misaligned)
//   st_addr, st_data     byte address, right-justified store data
//   misalign             pulse: offered store is misaligned and was dropped
//   mem_rd_en/mem_wr_en  memory read / full-word write strobes
//   mem_addr             word-aligned address (0 while idle)
//   mem_rdata            read data, valid the cycle after mem_rd_en
//   mem_wdata            merged write data
//   empty                nothing pending and FSM idle (loads may proceed)
//   count                occupied queue entries
// -----------------------------------------------------------------------------
module store_merge_buffer #(
  parameter int WIDTH = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [1:0]       st_size,
  input  logic [AW-1:0]    st_addr,
  input  logic [WIDTH-1:0] st_data,
  output logic             misalign,
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int NB = WIDTH / 8;
  localparam int OB = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam logic [NB-1:0] FULL_MASK = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [AW-1:0]    q_addr [DEPTH];
  logic [WIDTH-1:0] q_data [DEPTH];
  logic [NB-1:0]    q_mask [DEPTH];

  logic [PW-1:0] head, tail, tail_last;
  logic [CW-1:0] count_q;
  logic [1:0]    state;

  logic [NB-1:0]    req_mask;
  logic [WIDTH-1:0] req_data;
  logic [AW-1:0]    req_waddr;
  logic             req_bad;
  logic             full, push, pop, merge;
  logic [NB-1:0]    head_mask;
  logic             head_full;

  // Request decode: lane mask, lane-replicated data, alignment check.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    req_mask  = '0;
    req_data  = '0;
    req_bad   = 1'b0;
    req_waddr = {st_addr[AW-1:OB], {OB{1'b0}}};
    case (st_size)
      2'b00: begin
        req_mask[st_addr[OB-1:0]] = 1'b1;
        req_data = {NB{st_data[7:0]}};
      end
      2'b01: begin
        req_mask[{st_addr[OB-1:1], 1'b0} +: 2] = 2'b11;
        req_data = {(NB/2){st_data[15:0]}};
        req_bad  = st_addr[0];
      end
      2'b10: begin
        req_mask = FULL_MASK;
        req_data = st_data;
        req_bad  = |st_addr[OB-1:0];
      end
      default: req_bad = 1'b1;
    endcase
  end

  assign full      = (count_q == CW'(DEPTH));
  assign st_ready  = !full;
  assign tail_last = tail - PW'(1);
  assign head_mask = q_mask[head];
  assign head_full = (head_mask == FULL_MASK);

`ifdef STORE_COALESCE_EN
  // The tail is safe to modify unless it is also the head the FSM is draining.
  assign merge = st_valid && !req_bad && (count_q != '0)
              && (q_addr[tail_last] == req_waddr)
              && ((state == S_IDLE) || (count_q >= CW'(2)));
`else
  assign merge = 1'b0;
`endif

  assign push     = st_valid && !req_bad && !full && !merge;
  assign pop      = (state == S_WRITE);
  assign misalign = st_valid && req_bad;

  assign mem_rd_en = (state == S_READ);
  assign mem_wr_en = (state == S_WRITE);
  assign mem_addr  = (state == S_IDLE) ? '0 : q_addr[head];
  assign empty     = (count_q == '0) && (state == S_IDLE);
  assign count     = count_q;

  // Write data: new bytes where masked; the remaining lanes come from the
  // word read back for partial entries.
  always_comb begin
    mem_wdata = '0;
    if (state == S_WRITE) begin
      for (int i = 0; i < NB; i++) begin
        if (head_mask[i])
          mem_wdata[8*i +: 8] = q_data[head][8*i +: 8];
        else if (!head_full)
          mem_wdata[8*i +: 8] = mem_rdata[8*i +: 8];
      end
    end
  end

  // Control state: FSM, pointers, occupancy.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state   <= S_IDLE;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      case (state)
        S_IDLE:  if (count_q != '0) state <= head_full ? S_WRITE : S_READ;
        S_READ:  state <= S_WRITE;
        S_WRITE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Entry storage.
  // NOTE: the entry array is not reset; resetting the pointers and count is
  // enough to make every stale entry invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= req_waddr;
      q_data[tail] <= req_data;
      q_mask[tail] <= req_mask;
    end
    if (merge) begin
      q_mask[tail_last] <= q_mask[tail_last] | req_mask;
      for (int i = 0; i < NB; i++)
        if (req_mask[i]) q_data[tail_last][8*i +: 8] <= req_data[8*i +: 8];
    end
  end

endmodule
